// File: rtl/instr_loader_pkg.sv
// Purpose : shared definitions for the instruction loader (state encoding,
//           instruction width, default memory depth, word-count legality check).
// Contents: INSTR_W, DEPTH_DEF, WC_W, state_t, count_legal().
package instr_loader_pkg;

   // Instruction word width and default number of writable memory words.
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned DEPTH_DEF = 32;

   // Width of the word_count request field.
   localparam int unsigned WC_W      = 6;

   // Loader FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // A load request is legal only for 1..depth words.
   function automatic logic count_legal(input logic [WC_W-1:0] wc,
                                        input int unsigned     depth);
      return (wc != '0) && (32'(wc) <= depth);
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Purpose : bundles the loader's request, byte-stream and memory-write signals.
// Latency : n/a (wires only).
// Backpressure: byte_ready/byte_valid handshake on the byte stream.
// Modports: master = host side (drives start/word_count/byte stream),
//           slave  = loader side (drives byte_ready, memory port and status).
interface instr_loader_if
   import instr_loader_pkg::*;
#(
   parameter int AW = 32
) ();

   logic               start;
   logic [WC_W-1:0]    word_count;
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [INSTR_W-1:0] mem_wdata;
   logic               cpu_hold;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, word_count, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
   );

   modport slave (
      input  start, word_count, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
   );

endinterface

// File: rtl/instr_loader.sv
// Purpose : assembles a big-endian byte stream into 32-bit words and writes
//           them to consecutive instruction-memory addresses, holding the CPU.
// Latency : mem_we rises the cycle after the 4th byte of a word is accepted.
// Backpressure: byte_ready is high only in LOAD; a stalled byte_valid just waits.
// Ports   : clk, rst_n (synchronous, active-low);
//           bus (slave modport): start/word_count request, byte_in/byte_valid/
//           byte_ready stream, mem_we/mem_addr/mem_wdata write port,
//           cpu_hold/busy/done/err status.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int          AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_loader_if.slave bus
);

   state_t             state_q;
   logic [WC_W-1:0]    count_q;
   logic [WC_W-1:0]    idx_q;
   logic [1:0]         byte_cnt_q;
   logic [INSTR_W-1:0] word_q;

   logic               byte_ready_q;
   logic               mem_we_q;
   logic [AW-1:0]      mem_addr_q;
   logic [INSTR_W-1:0] mem_wdata_q;
   logic               cpu_hold_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;

   logic [INSTR_W-1:0] word_d;
   logic               accept;
   logic               last_word;

   // Most significant byte arrives first, so each new byte shifts in at the bottom.
   assign word_d    = {word_q[INSTR_W-9:0], bus.byte_in};
   assign accept    = bus.byte_valid && byte_ready_q;
   assign last_word = (idx_q == count_q - 1'b1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         idx_q        <= '0;
         byte_cnt_q   <= '0;
         word_q       <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         mem_we_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (count_legal(bus.word_count, DEPTH)) begin
                     count_q      <= bus.word_count;
                     idx_q        <= '0;
                     byte_cnt_q   <= '0;
                     state_q      <= ST_LOAD;
                     byte_ready_q <= 1'b1;
                     cpu_hold_q   <= 1'b1;
                     busy_q       <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (accept) begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     // Write port is registered here so mem_we appears in WRITE.
                     state_q      <= ST_WRITE;
                     byte_ready_q <= 1'b0;
                     mem_we_q     <= 1'b1;
                     mem_addr_q   <= AW'(idx_q);
                     mem_wdata_q  <= word_d;
                  end
               end
            end

            ST_WRITE: begin
               if (last_word) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q        <= idx_q + 1'b1;
                  byte_cnt_q   <= '0;
                  state_q      <= ST_LOAD;
                  byte_ready_q <= 1'b1;
               end
            end

            ST_DONE: begin
               state_q    <= ST_IDLE;
               cpu_hold_q <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.cpu_hold   = cpu_hold_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: hand-computed words, addresses and strobes.
module tb_instr_loader;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   instr_loader_if #(.AW(32)) bus ();

   instr_loader #(.DEPTH(32), .AW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Write log, filled by the monitor only; tests use base offsets.
   logic [31:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int done_cnt = 0;
   int err_cnt  = 0;
   int over_cnt = 0;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wdata);
         if (bus.mem_addr >= 32) over_cnt++;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1)  err_cnt++;
   end

   task automatic do_start(input logic [5:0] wc);
      bus.start      = 1'b1;
      bus.word_count = wc;
      @(negedge clk);
      bus.start      = 1'b0;
   endtask

   // Present one byte and hold it until the loader has taken it.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      while (bus.byte_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.byte_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_byte_timeout byte_ready=%b required 1", bus.byte_ready);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic test_reset;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.word_count = '0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.busy, bus.done, bus.err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got rdy/we/hold/busy/done/err=%b required 000000",
                  {bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.busy, bus.done, bus.err});
      end
      checks++;
      if (bus.mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr got %h required 0", bus.mem_addr);
      end
      checks++;
      if (bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_wdata got %h required 0", bus.mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int wb = wr_addr_q.size();
      int db = done_cnt;
      do_start(6'd2);
      checks++;
      if ({bus.byte_ready, bus.cpu_hold, bus.busy} !== 3'b111) begin
         errors++;
         $display("FAIL basic_enter_load got rdy/hold/busy=%b required 111",
                  {bus.byte_ready, bus.cpu_hold, bus.busy});
      end
      send_word(32'h8C010001);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd0, 32'h8C010001}) begin
         errors++;
         $display("FAIL basic_write0 got we=%b addr=%h data=%h required we=1 addr=0 data=8c010001",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.byte_ready} !== {1'b0, 32'd0, 32'h8C010001, 1'b1}) begin
         errors++;
         $display("FAIL basic_hold got we=%b addr=%h data=%h rdy=%b required we=0 addr=0 data=8c010001 rdy=1",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.byte_ready);
      end
      send_word(32'h20000001);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd1, 32'h20000001}) begin
         errors++;
         $display("FAIL basic_write1 got we=%b addr=%h data=%h required we=1 addr=1 data=20000001",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy, bus.cpu_hold, bus.mem_we} !== 4'b1010) begin
         errors++;
         $display("FAIL basic_done_cycle got done/busy/hold/we=%b required 1010",
                  {bus.done, bus.busy, bus.cpu_hold, bus.mem_we});
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.cpu_hold, bus.byte_ready} !== 3'b000) begin
         errors++;
         $display("FAIL basic_back_idle got done/hold/rdy=%b required 000",
                  {bus.done, bus.cpu_hold, bus.byte_ready});
      end
      checks++;
      if ((wr_addr_q.size() - wb) != 2 || (done_cnt - db) != 1) begin
         errors++;
         $display("FAIL basic_counts got writes=%0d dones=%0d required 2 1",
                  wr_addr_q.size() - wb, done_cnt - db);
      end
   endtask

   task automatic test_gaps;
      int bad = 0;
      int wb = wr_addr_q.size();
      do_start(6'd1);
      for (int k = 0; k < 4; k++) begin
         repeat (3) begin
            @(negedge clk);
            if (bus.cpu_hold !== 1'b1 || bus.mem_we !== 1'b0 || bus.busy !== 1'b1) bad++;
         end
         send_byte(8'hA5);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL gaps_hold got %0d bad gap cycles required 0", bad);
      end
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd0, 32'hA5A5A5A5}) begin
         errors++;
         $display("FAIL gaps_write got we=%b addr=%h data=%h required we=1 addr=0 data=a5a5a5a5",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL gaps_done got %b required 1", bus.done);
      end
      @(negedge clk);
      checks++;
      if ((wr_addr_q.size() - wb) != 1 || bus.cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL gaps_end got writes=%0d hold=%b required 1 0",
                  wr_addr_q.size() - wb, bus.cpu_hold);
      end
   endtask

   task automatic test_illegal;
      int wb = wr_addr_q.size();
      int eb = err_cnt;
      do_start(6'd0);
      checks++;
      if ({bus.err, bus.cpu_hold, bus.busy, bus.byte_ready, bus.mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL illegal_zero got err/hold/busy/rdy/we=%b required 10000",
                  {bus.err, bus.cpu_hold, bus.busy, bus.byte_ready, bus.mem_we});
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err_pulse got %b required 0", bus.err);
      end
      do_start(6'd33);
      checks++;
      if ({bus.err, bus.cpu_hold, bus.busy, bus.byte_ready, bus.mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL illegal_33 got err/hold/busy/rdy/we=%b required 10000",
                  {bus.err, bus.cpu_hold, bus.busy, bus.byte_ready, bus.mem_we});
      end
      repeat (2) @(negedge clk);
      checks++;
      if ((err_cnt - eb) != 2 || (wr_addr_q.size() - wb) != 0 || bus.cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL illegal_counts got errs=%0d writes=%0d hold=%b required 2 0 0",
                  err_cnt - eb, wr_addr_q.size() - wb, bus.cpu_hold);
      end
   endtask

   task automatic test_full;
      int wb = wr_addr_q.size();
      int db = done_cnt;
      int ob = over_cnt;
      do_start(6'd32);
      for (int w = 0; w < 32; w++)
         send_word({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
      repeat (3) @(negedge clk);
      checks++;
      if ((wr_addr_q.size() - wb) != 32 || (done_cnt - db) != 1 || over_cnt != ob) begin
         errors++;
         $display("FAIL full_counts got writes=%0d dones=%0d over=%0d required 32 1 0",
                  wr_addr_q.size() - wb, done_cnt - db, over_cnt - ob);
      end
      if ((wr_addr_q.size() - wb) == 32) begin
         for (int i = 0; i < 32; i++) begin
            logic [31:0] exp_d;
            exp_d = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            checks++;
            if (wr_addr_q[wb+i] !== 32'(i) || wr_data_q[wb+i] !== exp_d) begin
               errors++;
               $display("FAIL full_word%0d got addr=%h data=%h required addr=%h data=%h",
                        i, wr_addr_q[wb+i], wr_data_q[wb+i], 32'(i), exp_d);
            end
         end
      end
   endtask

   task automatic test_reset_abort;
      int wb = wr_addr_q.size();
      int db = done_cnt;
      do_start(6'd3);
      send_word(32'hDEADBEEF);
      send_byte(8'h12);
      send_byte(8'h34);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.busy, bus.done, bus.err} !== 6'b0 ||
          bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL abort_reset_vals got flags=%b addr=%h data=%h required 000000 0 0",
                  {bus.byte_ready, bus.mem_we, bus.cpu_hold, bus.busy, bus.done, bus.err},
                  bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      rst_n          = 1'b1;
      bus.byte_in    = 8'h55;
      bus.byte_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.byte_valid = 1'b0;
      checks++;
      if ((wr_addr_q.size() - wb) != 1 || (done_cnt - db) != 0 || bus.byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_more got writes=%0d dones=%0d rdy=%b required 1 0 0",
                  wr_addr_q.size() - wb, done_cnt - db, bus.byte_ready);
      end
      if ((wr_addr_q.size() - wb) >= 1) begin
         checks++;
         if (wr_addr_q[wb] !== 32'd0 || wr_data_q[wb] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL abort_first_word got addr=%h data=%h required 0 deadbeef",
                     wr_addr_q[wb], wr_data_q[wb]);
         end
      end
      do_start(6'd1);
      send_word(32'h11223344);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd0, 32'h11223344}) begin
         errors++;
         $display("FAIL abort_reload got we=%b addr=%h data=%h required we=1 addr=0 data=11223344",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_start_ignored;
      int wb = wr_addr_q.size();
      int db = done_cnt;
      int eb = err_cnt;
      do_start(6'd2);
      send_byte(8'h01);
      send_byte(8'h02);
      do_start(6'd1);
      send_byte(8'h03);
      send_byte(8'h04);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd0, 32'h01020304}) begin
         errors++;
         $display("FAIL ign_write0 got we=%b addr=%h data=%h required we=1 addr=0 data=01020304",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      do_start(6'd5);
      send_word(32'h0A0B0C0D);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'd1, 32'h0A0B0C0D}) begin
         errors++;
         $display("FAIL ign_write1 got we=%b addr=%h data=%h required we=1 addr=1 data=0a0b0c0d",
                  bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ((wr_addr_q.size() - wb) != 2 || (done_cnt - db) != 1 || (err_cnt - eb) != 0 ||
          bus.cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL ign_counts got writes=%0d dones=%0d errs=%0d hold=%b required 2 1 0 0",
                  wr_addr_q.size() - wb, done_cnt - db, err_cnt - eb, bus.cpu_hold);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_gaps;
      test_illegal;
      test_full;
      test_reset_abort;
      test_start_ignored;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
